// File: rtl/reset_sequencer.sv
// ============================================================================
// Module   : reset_sequencer
// Purpose  : Ordered reset-release controller. Asserts all downstream domain
//            resets together on power-on or a software request, holds them,
//            then releases them one at a time in index order. Each release is
//            gated by a per-stage ready input and spaced by a programmable gap.
// Options  : RSTSEQ_TIMEOUT_EN - enables the WAIT-state watchdog that
//            force-releases a stalled stage and sets a sticky timeout_err.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module reset_sequencer #(
  parameter int NUM_STAGES     = 4,
  parameter int HOLD_CYCLES    = 8,
  parameter int GAP_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 16
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  sw_rst_req,
  input  logic [NUM_STAGES-1:0] stage_ready,
  output logic [NUM_STAGES-1:0] out_rst_n,
  output logic                  busy,
  output logic                  sw_rst_ack,
  output logic                  timeout_err
);

  localparam int IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

  localparam logic [CNT_W-1:0] C_HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_GAP_LAST  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [IDX_W-1:0] C_IDX_LAST  = IDX_W'(NUM_STAGES - 1);

  // Reject configurations whose cycle limits do not fit the shared counter.
  generate
    if ((NUM_STAGES < 1) || (HOLD_CYCLES < 1) || (GAP_CYCLES < 0) ||
        (((HOLD_CYCLES - 1) >> CNT_W) != 0) || ((GAP_CYCLES >> CNT_W) != 0) ||
        ((TIMEOUT_CYCLES >> CNT_W) != 0)) begin : g_param_check
      $error("reset_sequencer: illegal parameter combination");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_HOLD = 2'd0,
    S_WAIT = 2'd1,
    S_GAP  = 2'd2,
    S_RUN  = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    sw_pend_q, sw_pend_d;
  logic [NUM_STAGES-1:0]   out_q, out_d;
  logic                    ack_q, ack_d;
  logic                    release_now;

`ifdef RSTSEQ_TIMEOUT_EN
  localparam logic [CNT_W-1:0] C_TO_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  logic                    to_err_q, to_err_d;
`endif

  // Next-state logic; a software request overrides everything else on its edge.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    sw_pend_d   = sw_pend_q;
    out_d       = out_q;
    ack_d       = 1'b0;
    release_now = 1'b0;
`ifdef RSTSEQ_TIMEOUT_EN
    to_err_d    = to_err_q;
`endif

    case (state_q)
      S_HOLD: begin
        if (cnt_q == C_HOLD_LAST) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_WAIT: begin
        release_now = stage_ready[idx_q];
`ifdef RSTSEQ_TIMEOUT_EN
        // cnt doubles as the watchdog: it counts edges spent without ready.
        if (!stage_ready[idx_q]) begin
          if (cnt_q == C_TO_LAST) begin
            release_now = 1'b1;
            to_err_d    = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
`endif
        if (release_now) begin
          out_d[idx_q] = 1'b1;
          cnt_d        = '0;
          if (idx_q == C_IDX_LAST) begin
            state_d = S_RUN;
            if (sw_pend_q) begin
              ack_d     = 1'b1;
              sw_pend_d = 1'b0;
            end
          end else if (GAP_CYCLES == 0) begin
            idx_d = idx_q + 1'b1;
          end else begin
            state_d = S_GAP;
          end
        end
      end

      S_GAP: begin
        if (cnt_q == C_GAP_LAST) begin
          state_d = S_WAIT;
          cnt_d   = '0;
          idx_d   = idx_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_RUN: begin
        // Released stages ignore their ready inputs from here on.
      end

      default: begin
        state_d = S_HOLD;
        cnt_d   = '0;
        idx_d   = '0;
        out_d   = '0;
      end
    endcase

    if (sw_rst_req) begin
      out_d     = '0;
      state_d   = S_HOLD;
      cnt_d     = '0;
      idx_d     = '0;
      sw_pend_d = 1'b1;
      ack_d     = 1'b0;
    end
  end

  // State and output registers; RST_N asserts all resets with no clock needed.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= S_HOLD;
      cnt_q     <= '0;
      idx_q     <= '0;
      sw_pend_q <= 1'b0;
      out_q     <= '0;
      ack_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      sw_pend_q <= sw_pend_d;
      out_q     <= out_d;
      ack_q     <= ack_d;
    end
  end

`ifdef RSTSEQ_TIMEOUT_EN
  // Sticky watchdog flag: only RST_N clears it, software resets do not.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      to_err_q <= 1'b0;
    end else begin
      to_err_q <= to_err_d;
    end
  end

  assign timeout_err = to_err_q;
`else
  assign timeout_err = 1'b0;
`endif

  assign out_rst_n  = out_q;
  assign busy       = (state_q != S_RUN);
  assign sw_rst_ack = ack_q;

endmodule

`default_nettype wire
